// File: rtl/z80_bus_bridge.sv
// Z80 host bus front end for the GPU control register bank: synchronises the
// host strobes, decodes the GPU window and sequences single writes and latency-aware reads.
`timescale 1ns/1ps
module z80_bus_bridge #(
  parameter int HOST_ADDR_W = 22,
  parameter int GPU_ADDR_W  = 20,
  parameter logic [HOST_ADDR_W-1:0] WINDOW_BASE = 22'h300000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   z80_mreq_n,
  input  logic                   z80_wr_n,
  input  logic                   z80_rd_n,
  input  logic [HOST_ADDR_W-1:0] z80_addr,
  input  logic [7:0]             z80_data_in,
  output logic                   we,
  output logic [GPU_ADDR_W-1:0]  addr_out,
  output logic [7:0]             wr_data,
  input  logic [7:0]             reg_data_in,
  output logic [7:0]             z80_data_out,
  output logic                   z80_data_oe,
  output logic                   z80_wait_n
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_RD_CAP, S_DONE} state_t;

  state_t     r_state, w_next;
  logic [1:0] r_mreq_sync, r_wr_sync, r_rd_sync;
  logic [1:0] r_settle;
  logic       r_armed, r_is_rd;
  logic       w_mreq_n, w_wr_n, w_rd_n, w_in_win, w_decode, w_start;

  assign w_mreq_n = r_mreq_sync[1];
  assign w_wr_n   = r_wr_sync[1];
  assign w_rd_n   = r_rd_sync[1];
  assign w_in_win = (z80_addr[HOST_ADDR_W-1:GPU_ADDR_W] == WINDOW_BASE[HOST_ADDR_W-1:GPU_ADDR_W]);
  assign w_decode = r_armed && !w_mreq_n;
  assign w_start  = (r_state == S_IDLE) && (w_next != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mreq_sync <= '1;
      r_wr_sync   <= '1;
      r_rd_sync   <= '1;
      r_settle    <= '0;
      r_armed     <= 1'b0;
    end else begin
      r_mreq_sync <= {r_mreq_sync[0], z80_mreq_n};
      r_wr_sync   <= {r_wr_sync[0], z80_wr_n};
      r_rd_sync   <= {r_rd_sync[0], z80_rd_n};
      r_settle    <= {r_settle[0], 1'b1};
      // The synchronisers' reset value of 1 is not a real observation of mreq_n
      // high, so only trust them once they have been refilled from the pin.
      if (r_settle[1] && w_mreq_n)
        r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_decode) begin
          if (!w_in_win)               w_next = S_DONE;
          else if (!w_wr_n && w_rd_n)  w_next = S_WRITE;
          else if (!w_rd_n && w_wr_n)  w_next = S_READ;
          else if (!w_rd_n && !w_wr_n) w_next = S_DONE;
        end
      end
      S_WRITE:  w_next = S_DONE;
      S_READ:   w_next = S_RD_CAP;
      S_RD_CAP: w_next = S_DONE;
      S_DONE:   if (w_mreq_n) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_out     <= '0;
      wr_data      <= '0;
      z80_data_out <= '0;
      r_is_rd      <= 1'b0;
    end else begin
      if (w_start) begin
        r_is_rd <= (w_next == S_READ);
        if (w_next == S_WRITE || w_next == S_READ)
          addr_out <= z80_addr[GPU_ADDR_W-1:0];
        if (w_next == S_WRITE)
          wr_data <= z80_data_in;
      end
      if (r_state == S_RD_CAP)
        z80_data_out <= reg_data_in;
    end
  end

  always_comb begin
    we          = (r_state == S_WRITE);
    z80_wait_n  = !((r_state == S_READ) || (r_state == S_RD_CAP));
    z80_data_oe = (r_state == S_DONE) && r_is_rd && !w_rd_n;
  end

endmodule

// File: doc/z80_bus_bridge.md
# z80_bus_bridge

Host-side front end for the GPU hardware control register bank. It synchronises the asynchronous Z80 memory strobes into the GPU clock domain and decodes accesses that fall inside the GPU window. Each decoded write becomes exactly one single-cycle write strobe with held address and data. Each decoded read drives the address, waits out the register bank's one-cycle registered read latency, captures the returned byte and presents it on the host data bus until the host cycle ends.

## Interface
Parameters:
- HOST_ADDR_W, 22, host address width (MMU-extended Z80 address).
- GPU_ADDR_W, 20, width of address driven to the register bank.
- WINDOW_BASE, 22'h300000, host address of the GPU window; bits [HOST_ADDR_W-1:GPU_ADDR_W] are compared.

Ports:
- clk, in, 1, GPU system clock.
- rst, in, 1, reset, asynchronous, active-high.
- z80_mreq_n, in, 1, host memory request, asynchronous, active-low.
- z80_wr_n, in, 1, host write strobe, asynchronous, active-low.
- z80_rd_n, in, 1, host read strobe, asynchronous, active-low.
- z80_addr, in, HOST_ADDR_W, host address; stable while z80_mreq_n is low.
- z80_data_in, in, 8, host write data; stable while z80_wr_n is low.
- we, out, 1, write strobe to the register bank.
- addr_out, out, GPU_ADDR_W, address to the register bank.
- wr_data, out, 8, write data to the register bank.
- reg_data_in, in, 8, registered read data from the register bank.
- z80_data_out, out, 8, captured read byte to the host.
- z80_data_oe, out, 1, host data bus output enable.
- z80_wait_n, out, 1, host wait request, active-low.

## Operation
- Synchronisation: z80_mreq_n, z80_wr_n and z80_rd_n each pass through a 2-flop synchroniser. The synchronisers reset to 1. Address and data are sampled only in the IDLE-to-access transition, when they are guaranteed stable.
- armed flag: cleared by reset and set once synced mreq_n has been seen high. No access is decoded while armed is 0, so a strobe already low at reset release is ignored.
- in_win: z80_addr[HOST_ADDR_W-1:GPU_ADDR_W] == WINDOW_BASE[HOST_ADDR_W-1:GPU_ADDR_W].
- IDLE
  - Requires armed, synced mreq_n == 0 and in_win.
  - wr_n == 0 and rd_n == 1: latch addr_out <= z80_addr[GPU_ADDR_W-1:0] and wr_data <= z80_data_in, then go to WRITE.
  - rd_n == 0 and wr_n == 1: latch addr_out, then go to READ.
  - Both strobes low (bus fault): go to DONE with no access.
  - mreq_n low but out of window: go to DONE with no access, no oe, no wait.
- WRITE: we = 1 for this single cycle, then go to DONE.
- READ: z80_wait_n = 0 and addr_out held; the register bank samples addr_out at the end of this cycle. Go to RD_CAP.
- RD_CAP: z80_wait_n = 0; z80_data_out <= reg_data_in at the end of the cycle. Go to DONE.
- DONE
  - z80_data_oe = 1 only if the access was an in-window read and synced rd_n == 0.
  - Leave for IDLE when synced mreq_n == 1.
  - One host cycle produces at most one access.
- addr_out, wr_data and z80_data_out hold their last values between accesses.

## Timing
- Reset values: we = 0, addr_out = 0, wr_data = 0, z80_data_out = 0, z80_data_oe = 0, z80_wait_n = 1, state = IDLE, armed = 0.
- Reset mid-access returns to IDLE immediately with all outputs at their reset values. A write that has not yet pulsed we is dropped.
- Write latency: we asserts 3 clk after the falling edge of z80_wr_n (2 synchroniser cycles plus the IDLE decode), for exactly 1 clk.
- Read latency:
  - z80_wait_n falls 3 clk after z80_rd_n falls and stays low for 2 clk.
  - z80_data_out is valid and z80_data_oe is asserted in the cycle after RD_CAP.
  - z80_data_oe drops 2 clk after z80_rd_n rises, through the synchroniser. Host bus turnaround must tolerate this.
- Host requirement: the strobe must stay low for at least 4 clk, unless the host honours z80_wait_n.
- Back-to-back host cycles: a new access is decoded only after synced mreq_n has been high for at least 1 clk.

## Test plan
- Write: mreq_n/wr_n low, addr 22'h300010, data 8'hA5 -> exactly one cycle with we = 1, addr_out = 20'h00010, wr_data = 8'hA5, 3 clk after the strobe edge; no second pulse for the rest of the cycle.
- Read: model reg_data_in as the register at addr_out delayed 1 clk, register 8'h05 = 8'h3C -> z80_wait_n low for 2 clk, then z80_data_out = 8'h3C with z80_data_oe = 1 until 2 clk after rd_n rises.
- Out of window: write to 22'h100010 -> we stays 0, z80_wait_n stays 1, z80_data_oe stays 0.
- Bus fault: wr_n and rd_n both low in window -> no we, no oe; the next normal write completes correctly.
- Reset release with mreq_n/wr_n already low -> no we. After the strobes go high and a fresh write arrives, exactly one we.
- Reset mid-read asserted during RD_CAP -> z80_wait_n = 1 and z80_data_oe = 0 immediately. Outputs return to reset values and the next read returns correct data.
